inst_rom_responder: RTL
=======================

// Module: inst_rom_responder
// PURPOSE
//  Responder end of the core instruction-fetch interface: takes core rom_addr_o/rom_en_o, returns inst_i.
//  Word-addressed synchronous instruction RAM, 1-cycle read latency.
//  Beat-wise load port (valid/ready) writes program images; fetches are fenced to NOP while loading.
//  Misaligned/out-of-range fetches are flagged and counted.
// PARAMETERS
//  AW        10            log2 of depth in 32-bit words (1024 words)
//  BASE      32'h0000_0000 byte address of word 0
//  NOP       32'h0000_0013 addi x0,x0,0; returned on any fenced or invalid fetch
//  BOOT_LOAD 1             1: leave reset in LOAD; 0: leave reset in RUN
// PORTS
//  clk         in  1   clock, all state on rising edge
//  rst         in  1   synchronous, active-high reset
//  rom_addr_i  in  32  fetch byte address (core rom_addr_o)
//  rom_en_i    in  1   fetch enable (core rom_en_o); 0 = core stalled
//  inst_o      out 32  fetched instruction (core inst_i)
//  fetch_err_o out 1   1-cycle pulse aligned with inst_o: last fetch invalid
//  err_cnt_o   out 16  saturating count of invalid fetches
//  ld_start_i  in  1   request reload; honoured only in RUN
//  ld_valid_i  in  1   load beat valid
//  ld_ready_o  out 1   load beat accept; 1 only in LOAD
//  ld_addr_i   in  32  load byte address
//  ld_data_i   in  32  load word
//  ld_last_i   in  1   final beat of image
//  ld_busy_o   out 1   1 in LOAD or DRAIN
//  ld_err_o    out 1   sticky: a load beat was dropped; cleared on LOAD entry
// BEHAVIOUR
//  Reset: state = BOOT_LOAD ? LOAD : RUN; inst_o = NOP; fetch_err_o = 0; err_cnt_o = 0; ld_err_o = 0.
//   RAM contents are not reset.
//  FSM:
//   RUN   --ld_start_i--> LOAD (ld_err_o cleared)
//   LOAD  --accepted beat with ld_last_i--> DRAIN
//   DRAIN --1 cycle--> RUN
//   ld_start_i is ignored in LOAD and DRAIN.
//  Load beat: accepted when ld_valid_i & ld_ready_o.
//   idx = (ld_addr_i - BASE) >> 2.
//   Written only if ld_addr_i[1:0] == 0 and (ld_addr_i - BASE) < 4 << AW.
//   Otherwise the beat is dropped and ld_err_o is set; a dropped beat with ld_last_i still ends LOAD.
//  Fetch, cycle N with rom_en_i = 1:
//   inst_o at N+1 = mem[(rom_addr_i - BASE) >> 2] when state == RUN at N and the address is valid.
//   Valid address: addr[1:0] == 0 and offset in range, 32-bit unsigned subtraction.
//   Invalid address (any state): inst_o = NOP, fetch_err_o = 1 at N+1, err_cnt_o += 1 (saturates at 16'hFFFF).
//   Valid address in LOAD/DRAIN: inst_o = NOP, no error.
//  rom_en_i = 0: inst_o holds its previous value; fetch_err_o = 0.
//  Read-during-write: a write cannot occur in RUN, so there is no RAW hazard.
//   DRAIN guarantees the last written word is visible to the first RUN fetch.
//  Reset mid-load: FSM returns to its reset state; partially written words remain in RAM.
// STRUCTURE
//  Shared package / include: state encodings (RUN = 2'd0, LOAD = 2'd1, DRAIN = 2'd2) and the NOP constant,
//   both shared with the core decode stage.
//  One sub-module: inst_ram (1R1W, registered read, no reset, AW-bit index) so it can be swapped for an FPGA BRAM macro.
//  FSM, address checks and counters stay in this module.
// TESTING
//  1. BOOT_LOAD = 1, rst then idle: inst_o = 32'h13, ld_busy_o = 1, ld_ready_o = 1;
//     a fetch at 0x0 returns 32'h13 with no error.
//  2. Load 0x0 <= 32'h00500093 and 0x4 <= 32'h00A00113 (last on 2nd beat):
//     DRAIN then RUN; fetch 0x0 gives 32'h00500093 and fetch 0x4 gives 32'h00A00113, each 1 cycle later.
//  3. RUN, fetch 0x2: inst_o = 32'h13 and fetch_err_o = 1 for one cycle, err_cnt_o = 1;
//     fetch 0x1000 (AW = 10) gives the same response, err_cnt_o = 2.
//  4. rom_en_i low for 3 cycles after fetching 0x4: inst_o stays 32'h00A00113, no error pulses.
//  5. Load beat to 0x3 with ld_last_i: ld_err_o = 1, the FSM still reaches RUN, RAM is unchanged;
//     a subsequent ld_start_i clears ld_err_o.
//  6. rst asserted during LOAD after 1 of 2 beats: inst_o = NOP, state = LOAD, err_cnt_o = 0;
//     the word written before reset is readable after reload completes.
//     Error counter preset to 16'hFFFF plus one invalid fetch: err_cnt_o stays 16'hFFFF.

Source files
------------

// File: rtl/inst_rom_responder_pkg.sv
// Shared fetch-interface definitions: loader state encoding, NOP constant and address check.
package inst_rom_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } ld_state_e;

  // Word-aligned and inside the 4<<aw byte window; off is already relative to BASE.
  function automatic logic word_addr_ok(input logic [WORD_W-1:0] off, input int unsigned aw);
    logic [WORD_W:0] span;
    span = 33'(1) << (aw + 2);
    return (off[1:0] == 2'b00) && ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/inst_rom_responder_inst_ram.sv
// 1R1W word RAM with registered read and no reset, replaceable by a vendor block RAM.
module inst_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction-fetch responder: loadable instruction RAM, fetch fencing while loading,
// and invalid-fetch flagging/counting.
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int unsigned       AW        = 10,
  parameter logic [WORD_W-1:0] BASE      = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP       = NOP_INST,
  parameter bit                BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rom_addr_i,
  input  logic              rom_en_i,
  output logic [WORD_W-1:0] inst_o,
  output logic              fetch_err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [WORD_W-1:0] ld_addr_i,
  input  logic [WORD_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_busy_o,
  output logic              ld_err_o
);

  ld_state_e         state;
  logic [WORD_W-1:0] f_off;
  logic [WORD_W-1:0] l_off;
  logic              fetch_ok;
  logic              ld_ok;
  logic              beat_acc;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              rd_sel;
  logic [WORD_W-1:0] inst_hold;

  assign f_off    = rom_addr_i - BASE;
  assign l_off    = ld_addr_i - BASE;
  assign fetch_ok = word_addr_ok(f_off, AW);
  assign ld_ok    = word_addr_ok(l_off, AW);
  assign beat_acc = ld_valid_i & ld_ready_o;
  assign ram_we   = beat_acc & ld_ok & ~rst;
  assign ram_re   = rom_en_i & fetch_ok & (state == ST_RUN) & ~rst;

  inst_ram #(
    .AW(AW),
    .DW(WORD_W)
  ) u_inst_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(l_off[AW+1:2]),
    .wdata(ld_data_i),
    .re   (ram_re),
    .raddr(f_off[AW+1:2]),
    .rdata(ram_rdata)
  );

  // Loader FSM; ready/busy are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT_LOAD ? ST_LOAD : ST_RUN;
      ld_ready_o <= BOOT_LOAD;
      ld_busy_o  <= BOOT_LOAD;
      ld_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ld_start_i) begin
            state      <= ST_LOAD;
            ld_ready_o <= 1'b1;
            ld_busy_o  <= 1'b1;
            ld_err_o   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            if (!ld_ok) ld_err_o <= 1'b1;
            if (ld_last_i) begin
              state      <= ST_DRAIN;
              ld_ready_o <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state     <= ST_RUN;
          ld_busy_o <= 1'b0;
        end
        default: begin
          state      <= ST_RUN;
          ld_ready_o <= 1'b0;
          ld_busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch response: RAM data only for valid RUN fetches, otherwise a held NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel      <= 1'b0;
      inst_hold   <= NOP;
      fetch_err_o <= 1'b0;
      err_cnt_o   <= '0;
    end else if (rom_en_i) begin
      if (!fetch_ok) begin
        rd_sel      <= 1'b0;
        inst_hold   <= NOP;
        fetch_err_o <= 1'b1;
        if (err_cnt_o != {CNT_W{1'b1}}) err_cnt_o <= err_cnt_o + CNT_W'(1);
      end else begin
        rd_sel      <= (state == ST_RUN);
        inst_hold   <= NOP;
        fetch_err_o <= 1'b0;
      end
    end else begin
      fetch_err_o <= 1'b0;
    end
  end

  assign inst_o = rd_sel ? ram_rdata : inst_hold;

endmodule
